spi_flash_read_ctrl: RTL and testbench

SPI-master read engine inside soc_top. It sits between the boot/XIP fetch path and the external N25Q-class flash on spi_cs/spi_clk/spi_mosi/spi_miso.
- Accepts one word-read request on a valid/ready interface.
- Issues a flash READ command with a 24-bit address, shifts in 4 data bytes, and returns one 32-bit little-endian word.
- SPI mode 0, single-bit I/O; spi_clk is derived from clk by an integer divider.

---
 rtl/spi_flash_read_ctrl.sv | 151 +++++++++++++++
 tb/tb_spi_flash_read_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_read_ctrl.sv
// SPI mode-0 single-bit flash word reader: READ (0x03) + 24-bit address, 4 data bytes LE.
// Define SPI_FAST_READ_EN to issue FAST_READ (0x0B) with 8 dummy clocks instead.
module spi_flash_read_ctrl #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CS_GAP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic        req_cs,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        spi_clk,
    output logic [1:0]  spi_cs,
    output logic        spi_mosi,
    input  logic        spi_miso
);

`ifdef SPI_FAST_READ_EN
    localparam logic [7:0]  CMD    = 8'h0B;
    localparam int unsigned NBITS  = 72;
    localparam int unsigned DSTART = 40;
`else
    localparam logic [7:0]  CMD    = 8'h03;
    localparam int unsigned NBITS  = 64;
    localparam int unsigned DSTART = 32;
`endif

    localparam int unsigned     DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned     GAP_W     = $clog2(CS_GAP + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_DONE = GAP_W'(CS_GAP);
    localparam logic [6:0]      BIT_LAST  = 7'(NBITS - 1);
    localparam logic [6:0]      BIT_DATA  = 7'(DSTART);
    localparam logic [6:0]      BIT_ADDR  = 7'd31;

    typedef enum logic [1:0] {StIdle, StShift, StResp, StGap} state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [6:0]         r_bit_cnt;
    logic [31:0]        r_shift;
    logic [31:0]        r_rsp_data;
    logic [1:0]         r_spi_cs;
    logic               r_spi_clk;
    logic               r_spi_mosi;
    logic               r_rsp_valid;
    logic               w_accept;
    logic               w_tick;
    logic               w_rise;
    logic               w_fall;
    logic               w_last;

    assign w_accept = req_valid && req_ready;
    assign w_tick   = (r_state == StShift) && (r_div_cnt == DIV_LAST);
    assign w_rise   = w_tick && !r_spi_clk;
    assign w_fall   = w_tick && r_spi_clk;
    assign w_last   = w_fall && (r_bit_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_next = StShift;
            StShift: if (w_last) w_state_next = StResp;
            StResp:  if (rsp_ready) w_state_next = StGap;
            StGap:   if (r_gap_cnt == GAP_DONE) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        req_ready = (r_state == StIdle) && (r_gap_cnt == GAP_DONE);
    end

    // Gap is timed from CS deassert, so it also runs while the response waits in StResp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap_cnt <= GAP_DONE;
        end else if (w_last) begin
            r_gap_cnt <= '0;
        end else if (r_state != StShift && r_gap_cnt != GAP_DONE) begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spi_cs    <= 2'b11;
            r_spi_clk   <= 1'b0;
            r_spi_mosi  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_div_cnt   <= '0;
        end else if (w_accept) begin
            r_spi_cs   <= req_cs ? 2'b01 : 2'b10;
            r_spi_clk  <= 1'b0;
            r_spi_mosi <= CMD[7];
            r_shift    <= {CMD, req_addr};
            r_bit_cnt  <= '0;
            r_div_cnt  <= '0;
        end else if (r_state == StShift) begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
            if (w_rise) begin
                r_spi_clk <= 1'b1;
                if (r_bit_cnt >= BIT_DATA) begin
                    r_shift <= {r_shift[30:0], spi_miso};
                end
            end
            if (w_fall) begin
                r_spi_clk <= 1'b0;
                r_bit_cnt <= r_bit_cnt + 7'd1;
                // r_shift[30] is the next command/address bit; zeros after bit 31.
                if (r_bit_cnt < BIT_ADDR) begin
                    r_spi_mosi <= r_shift[30];
                    r_shift    <= {r_shift[30:0], 1'b0};
                end else begin
                    r_spi_mosi <= 1'b0;
                end
                if (r_bit_cnt == BIT_LAST) begin
                    r_spi_cs    <= 2'b11;
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= {r_shift[7:0], r_shift[15:8], r_shift[23:16], r_shift[31:24]};
                end
            end
        end else if (r_state == StResp && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign spi_cs    = r_spi_cs;
    assign spi_clk   = r_spi_clk;
    assign spi_mosi  = r_spi_mosi;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_spi_flash_read_ctrl.sv
// Bench for spi_flash_read_ctrl: two DUTs (CLK_DIV=2 and CLK_DIV=1) against a behavioural flash.
module tb_spi_flash_read_ctrl;

    localparam int CS_GAP = 4;
`ifdef SPI_FAST_READ_EN
    localparam logic [7:0] CMD    = 8'h0B;
    localparam int         NBITS  = 72;
    localparam int         DSTART = 40;
`else
    localparam logic [7:0] CMD    = 8'h03;
    localparam int         NBITS  = 64;
    localparam int         DSTART = 32;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]        req_valid, req_ready, req_cs, rsp_valid, rsp_ready;
    logic [1:0]        spi_clk_w, spi_mosi_w, spi_miso_w;
    logic [1:0][23:0]  req_addr;
    logic [1:0][31:0]  rsp_data;
    logic [1:0][1:0]   spi_cs_w;

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int unsigned GDiv = (g == 0) ? 2 : 1;
        spi_flash_read_ctrl #(
            .CLK_DIV(GDiv),
            .CS_GAP (CS_GAP)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_addr (req_addr[g]),
            .req_cs   (req_cs[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_ready(rsp_ready[g]),
            .rsp_data (rsp_data[g]),
            .spi_clk  (spi_clk_w[g]),
            .spi_cs   (spi_cs_w[g]),
            .spi_mosi (spi_mosi_w[g]),
            .spi_miso (spi_miso_w[g])
        );
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] exp_q[$];
    logic [31:0] exp_cmd_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] fbyte(input logic [23:0] a);
        case (a)
            24'h000100: return 8'h11;
            24'h000101: return 8'h22;
            24'h000102: return 8'h33;
            24'h000103: return 8'h44;
            24'hFFFFFE: return 8'hAA;
            24'hFFFFFF: return 8'hBB;
            24'h000000: return 8'hCC;
            24'h000001: return 8'hDD;
            default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input logic [23:0] a);
        return {fbyte(a + 24'd3), fbyte(a + 24'd2), fbyte(a + 24'd1), fbyte(a)};
    endfunction

    // Flash model state, one slot per DUT.
    int          rises[2], falls[2], gap[2], t_r1[2], period[2];
    logic [31:0] sreg[2], cap_cmd[2];
    logic        mosi_after[2], prev_sclk[2], cs_low_prev[2], seen[2];
    logic [1:0]  exp_cs[2];

    initial begin
        int d;
        logic [23:0] a;
        logic [7:0] b;
        spi_miso_w = '0;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (!rst_n) begin
                    rises[g] = 0; falls[g] = 0; gap[g] = 0; seen[g] = 1'b0;
                    cs_low_prev[g] = 1'b0; prev_sclk[g] = 1'b0; spi_miso_w[g] = 1'b0;
                end else if (spi_cs_w[g] == 2'b11) begin
                    gap[g]++;
                    cs_low_prev[g] = 1'b0; rises[g] = 0; falls[g] = 0;
                    prev_sclk[g] = 1'b0; spi_miso_w[g] = 1'b0;
                end else begin
                    if (!cs_low_prev[g]) begin
                        if (seen[g]) check_eq("cs_gap_ok", 32'(gap[g] >= CS_GAP), 32'd1);
                        check_eq("cs_select", 32'(spi_cs_w[g]), 32'(exp_cs[g]));
                        seen[g] = 1'b1; gap[g] = 0; cs_low_prev[g] = 1'b1;
                        mosi_after[g] = 1'b0; sreg[g] = '0;
                    end
                    if (spi_clk_w[g] && !prev_sclk[g]) begin
                        rises[g]++;
                        if (rises[g] <= 32) sreg[g] = {sreg[g][30:0], spi_mosi_w[g]};
                        else mosi_after[g] = mosi_after[g] | spi_mosi_w[g];
                        if (rises[g] == 32) cap_cmd[g] = sreg[g];
                        if (rises[g] == 1) t_r1[g] = cyc;
                        if (rises[g] == 2) period[g] = cyc - t_r1[g];
                    end
                    if (!spi_clk_w[g] && prev_sclk[g]) begin
                        falls[g]++;
                        if (falls[g] >= DSTART && falls[g] < DSTART + 32) begin
                            d = falls[g] - DSTART;
                            a = sreg[g][23:0] + 24'(d / 8);
                            b = fbyte(a);
                            spi_miso_w[g] = b[7 - (d % 8)];
                        end
                    end
                    prev_sclk[g] = spi_clk_w[g];
                end
            end
        end
    end

    task automatic do_read(input int g, input logic [23:0] addr, input logic csel, input int hold);
        int n, t0, lat, div;
        logic [31:0] exp_d, exp_c, held;
        bit ok;
        div = (g == 0) ? 2 : 1;
        lat = 2 * NBITS * div;
        n = 0;
        while (!req_ready[g] && n < 1000) begin @(negedge clk); n++; end
        check_eq("req_ready_wait", 32'(req_ready[g]), 32'd1);
        if (!req_ready[g]) return;
        req_valid[g] = 1'b1; req_addr[g] = addr; req_cs[g] = csel;
        exp_cs[g] = csel ? 2'b01 : 2'b10;
        exp_q.push_back(exp_word(addr));
        exp_cmd_q.push_back({CMD, addr});
        @(posedge clk); @(negedge clk);
        t0 = cyc;
        if (hold == 0) req_valid[g] = 1'b0;
        req_addr[g] = ~addr; req_cs[g] = ~csel;
        n = 0;
        while (!rsp_valid[g] && n < lat + 100) begin @(negedge clk); n++; end
        check_eq("latency", 32'(cyc - t0), 32'(lat));
        exp_d = exp_q.pop_front();
        exp_c = exp_cmd_q.pop_front();
        if (!rsp_valid[g]) begin req_valid[g] = 1'b0; return; end
        if (hold > 0) begin
            ok = 1'b1; held = rsp_data[g];
            repeat (hold) begin
                @(negedge clk);
                if (rsp_data[g] !== held || req_ready[g] || spi_cs_w[g] !== 2'b11 || !rsp_valid[g])
                    ok = 1'b0;
            end
            check_eq("bp_hold", 32'(ok), 32'd1);
            req_valid[g] = 1'b0;
        end
        check_eq("rsp_data", rsp_data[g], exp_d);
        check_eq("cmd_addr", cap_cmd[g], exp_c);
        check_eq("mosi_after", 32'(mosi_after[g]), 32'd0);
        check_eq("sclk_period", 32'(period[g]), 32'(2 * div));
        rsp_ready[g] = 1'b1;
        @(posedge clk); @(negedge clk);
        rsp_ready[g] = 1'b0;
        check_eq("rsp_drop", 32'(rsp_valid[g]), 32'd0);
    endtask

    initial begin
        int n;
        bit ok;
        rst_n = 1'b0; req_valid = '0; req_cs = '0; rsp_ready = '0; req_addr = '0;
        exp_cs[0] = 2'b10; exp_cs[1] = 2'b10;
        repeat (3) @(negedge clk);
        check_eq("rst_req_ready", 32'(req_ready[0]), 32'd1);
        check_eq("rst_spi_cs", 32'(spi_cs_w[0]), 32'd3);
        check_eq("rst_spi_clk", 32'(spi_clk_w[0]), 32'd0);
        check_eq("rst_spi_mosi", 32'(spi_mosi_w[0]), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check_eq("rst_rsp_data", rsp_data[0], 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_read(0, 24'h000100, 1'b0, 0);
        do_read(0, 24'hFFFFFE, 1'b0, 0);
        do_read(0, 24'h012345, 1'b1, 500);
        do_read(0, 24'h00ABCD, 1'b0, 0);
        do_read(1, 24'h000100, 1'b1, 0);
        for (int i = 0; i < 4; i++) begin
            do_read(i % 2, 24'($urandom), 1'($urandom_range(0, 1)), 0);
        end

        // Abort mid-transfer, then confirm a clean fresh read.
        n = 0;
        while (!req_ready[0] && n < 1000) begin @(negedge clk); n++; end
        req_valid[0] = 1'b1; req_addr[0] = 24'h000100; req_cs[0] = 1'b0; exp_cs[0] = 2'b10;
        @(posedge clk); @(negedge clk);
        req_valid[0] = 1'b0;
        n = 0;
        while (rises[0] < 40 && n < 2000) begin @(negedge clk); n++; end
        check_eq("reach_bit40", 32'(rises[0] >= 40), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_spi_cs", 32'(spi_cs_w[0]), 32'd3);
        check_eq("abort_spi_clk", 32'(spi_clk_w[0]), 32'd0);
        check_eq("abort_mosi", 32'(spi_mosi_w[0]), 32'd0);
        check_eq("abort_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (rsp_valid[0]) ok = 1'b0;
        end
        check_eq("no_rsp_after_abort", 32'(ok), 32'd1);
        do_read(0, 24'h000100, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
